mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares one 4:1 bit-select datapath between four requesters. It owns the `sel` code of the shared mux, grants one requester at a time with a one-hot grant, and registers the selected data bit into `out` with a valid flag. It sits directly in front of the 4:1 select path and replaces any free-running or software-driven `sel` source.

## Interface
- `N_REQ`, 4: number of requesters; fixed at 4 in this revision.
- `SEL_W`, 2: width of `sel`; equals clog2(`N_REQ`).
- `HOLD_MAX`, 8: maximum consecutive grant cycles per owner. Used only when `ARB_TIMEOUT_EN` is defined; legal range 2..255.

- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  4  level request per requester; held high for as long as access is needed.
- `data`  in  4  shared datapath input; `data[i]` belongs to requester i.
- `gnt`  out  4  one-hot grant, registered.
- `sel`  out  2  index of current owner, registered; drives the shared mux.
- `out`  out  1  registered selected data bit.
- `out_valid`  out  1  high when `out` carries a granted requester's bit.

## Operation
- Two-state FSM: IDLE, GRANT.
- IDLE: if `req` != 0, pick the winner in rotating order `last+1, last+2, last+3, last` (mod 4); next edge: GRANT, `gnt` = one-hot(winner), `sel` = winner, `last` = winner. If `req` == 0, stay IDLE, `gnt` = 0.
- GRANT: stay while `req[sel]` = 1. When `req[sel]` = 0, next edge: IDLE, `gnt` = 0; `sel` holds its last value.
- Mandatory one dead IDLE cycle between any two grants, including same-requester re-grant; this is the bus turnaround.
- Changes on `req` bits of non-owners never affect the current grant.
- `last` resets to 3, so requester 0 has top priority after reset.
- `out` datapath: each edge, `out` <= `data[sel]` and `out_valid` <= 1 if state is GRANT, otherwise `out` <= 0 and `out_valid` <= 0.
- Reset values: state IDLE, `gnt` 0, `sel` 0, `out` 0, `out_valid` 0, `last` 3, hold counter 0.
- Reset asserted mid-grant: all outputs clear immediately and asynchronously. No grant is issued until the first rising edge after `reset` rises.

## Timing
- Request to grant: `req` sampled high at edge t (in IDLE) gives `gnt`/`sel` valid after edge t.
- Grant to data: `out`/`out_valid` follow GRANT by one cycle, so the first valid `out` appears after edge t+1.
- Release: `req[sel]` sampled low at edge t gives `gnt` low after edge t and `out_valid` low after edge t+1.
- Minimum grant length is 1 cycle. Back-to-back grants are spaced by exactly 1 IDLE cycle.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter equals `HOLD_MAX`-1 and any other `req` bit is high, the next edge forces IDLE even if `req[sel]` is still high.
  - If no other requester is pending, the counter saturates and the grant continues.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built and `HOLD_MAX` is ignored.
  - The owner keeps the grant until it drops `req`.

## Structure
- Package `arb_pkg` holds:
  - the state encoding (IDLE = 1'b0, GRANT = 1'b1);
  - `N_REQ`, `SEL_W`;
  - reset constant `LAST_RST` = 2'd3.
- Sub-module `rr_pick` is combinational. Inputs: `req[3:0]`, `last[1:0]`. Outputs: `any`, `win[1:0]`. It implements the rotating priority search.
- The top level holds the FSM, the `last`/`sel`/`gnt` registers, the optional counter and the output register.

## Test plan
- Single request: after reset, `req` = 4'b0100 → `gnt` = 4'b0100 and `sel` = 2 one edge later; with `data` = 4'b0100, `out` = 1 and `out_valid` = 1 one edge after that.
- Simultaneous requests: `req` = 4'b1111 held, each owner drops `req` after 2 grant cycles and reasserts → grant order 0, 1, 2, 3, 0, with one IDLE cycle between grants.
- Rotation skip: `last` = 1, `req` = 4'b1001 → grant goes to 3, not 0.
- Non-owner activity: owner 2 holds `req`; toggle `req[0]` and `req[3]` every cycle → `gnt` stays 4'b0100 and `sel` stays 2.
- Reset mid-grant: pull `reset` low while in GRANT → `gnt`, `out` and `out_valid` clear with no clock edge; after release, `req` = 4'b1111 grants 0 first.
- Timeout (`ARB_TIMEOUT_EN`, `HOLD_MAX` = 4): `req[1]` held with `req[2]` high → grant to 1 lasts 4 cycles, then IDLE, then grant to 2. With `req[2]` low, grant to 1 persists beyond 4 cycles.

Source files
------------

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the mux_rr_arbiter slice: requester count, select
// width, FSM state encoding, the reset value of the round-robin pointer and a
// one-hot helper.
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Pointer starts at the last requester so that requester 0 is searched first.
    localparam logic [SEL_W-1:0] LAST_RST = 2'd3;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority search. Candidates are visited in the order
// last+1, last+2, last+3, last (mod N_REQ); the first requesting one wins.
// Ports:
//   req  [N_REQ-1:0] in   level requests
//   last [SEL_W-1:0] in   most recent owner
//   any              out  at least one request is pending
//   win  [SEL_W-1:0] out  winning requester index (valid when any = 1)
// -----------------------------------------------------------------------------
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic             any,
    output logic [SEL_W-1:0] win
);

    logic [SEL_W-1:0] cand [N_REQ];
    logic [N_REQ-1:0] hit;

    // Candidate at search step gi; the 2-bit add wraps so step N_REQ-1 lands
    // back on 'last' itself (lowest priority).
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        assign cand[gi] = last + SEL_W'(gi + 1);
        assign hit[gi]  = req[cand[gi]];
    end

    always_comb begin
        any = |req;
        win = '0;
        // Walk from lowest to highest priority so the earliest step wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                win = cand[k];
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin arbiter owning the select code of a shared 4:1 bit mux. One
// requester is granted at a time (one-hot gnt, registered sel) and the selected
// data bit is registered into out with out_valid. Every grant is followed by
// one dead IDLE cycle before the next grant (bus turnaround).
// Build option: define ARB_TIMEOUT_EN to limit an owner to HOLD_MAX
// consecutive grant cycles while another requester is waiting.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   req   [3:0] in  level requests
//   data  [3:0] in  shared datapath input, data[i] belongs to requester i
//   gnt   [3:0] out one-hot grant (registered)
//   sel   [1:0] out current owner index (registered), drives the shared mux
//   out         out registered selected data bit
//   out_valid   out out carries a granted requester's bit
// -----------------------------------------------------------------------------
module mux_rr_arbiter
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] data,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             out,
    output logic             out_valid
);

    // HOLD_MAX only has an effect in the timeout build; values outside 2..255
    // are not supported by the 8-bit hold counter.
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_max_out_of_range
    end

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;

    logic             pick_any;
    logic [SEL_W-1:0] pick_win;
    logic             owner_req;
    logic             timeout;

    rr_pick u_rr_pick (
        .req  (req),
        .last (last_q),
        .any  (pick_any),
        .win  (pick_win)
    );

    assign owner_req = req[sel_q];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_q, hold_d;

    // Preempt only when the budget is spent and someone else is waiting;
    // gnt_q is one-hot on the owner while in GRANT, so it masks the owner out.
    assign timeout = (hold_q == HOLD_LAST) && (|(req & ~gnt_q));
`else
    assign timeout = 1'b0;
`endif

    // ---- state register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            last_q      <= LAST_RST;
            sel_q       <= '0;
            gnt_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
`ifdef ARB_TIMEOUT_EN
            hold_q      <= hold_d;
`endif
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (pick_any)              state_d = ST_GRANT;
            ST_GRANT: if (!owner_req || timeout) state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    // ---- registered output / datapath logic ----
    always_comb begin
        last_d = last_q;
        sel_d  = sel_q;
        gnt_d  = gnt_q;
`ifdef ARB_TIMEOUT_EN
        hold_d = hold_q;
`endif
        if (state_q == ST_IDLE) begin
            if (pick_any) begin
                gnt_d  = onehot(pick_win);
                sel_d  = pick_win;
                last_d = pick_win;
`ifdef ARB_TIMEOUT_EN
                hold_d = '0;
`endif
            end else begin
                gnt_d = '0;
            end
        end else if (state_d == ST_IDLE) begin
            // Release: sel keeps pointing at the previous owner.
            gnt_d = '0;
        end else begin
`ifdef ARB_TIMEOUT_EN
            // Saturate so a late-arriving competitor preempts immediately.
            if (hold_q != HOLD_LAST) begin
                hold_d = hold_q + 8'd1;
            end
`endif
        end

        out_d       = (state_q == ST_GRANT) ? data[sel_q] : 1'b0;
        out_valid_d = (state_q == ST_GRANT);
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
// Directed vector table, hand sequences for reset and timeout corners, and a
// randomized run against a behavioural round-robin model.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] data = '0;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       dut_out;
    logic       dut_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data      (data),
        .gnt       (gnt),
        .sel       (sel),
        .out       (dut_out),
        .out_valid (dut_valid)
    );

    typedef struct {
        logic       rst;   // pulse reset before applying this row
        logic [3:0] req;
        logic [3:0] data;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       out;
        logic       valid;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] d,
                                input logic [3:0] g, input logic [1:0] s,
                                input logic o, input logic v);
        vec_t x;
        x.rst = r; x.req = rq; x.data = d; x.gnt = g; x.sel = s; x.out = o; x.valid = v;
        vt.push_back(x);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] eg, input logic [1:0] es,
                             input logic eo, input logic ev);
        check({tag, ".gnt"}, 32'(gnt), 32'(eg));
        check({tag, ".sel"}, 32'(sel), 32'(es));
        check({tag, ".out"}, 32'(dut_out), 32'(eo));
        check({tag, ".valid"}, 32'(dut_valid), 32'(ev));
        $display("%s req=%b data=%b -> gnt=%b sel=%0d out=%b valid=%b", tag, req, data,
                 gnt, sel, dut_out, dut_valid);
    endtask

    // Reset is asserted and released away from the rising edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        data  = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---- behavioural model: owner index or -1 when the bus is idle ----
    int         m_owner, m_last, m_sel, m_hold;
    logic [3:0] m_gnt;
    logic       m_out, m_valid;

    function automatic void model_reset();
        m_owner = -1; m_last = 3; m_sel = 0; m_hold = 0;
        m_gnt = '0; m_out = 1'b0; m_valid = 1'b0;
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic [3:0] d);
        logic [3:0] others;
        m_valid = (m_owner >= 0);
        m_out   = (m_owner >= 0) ? d[m_sel] : 1'b0;
        if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (m_owner < 0 && r[c]) begin
                    m_owner = c; m_last = c; m_sel = c; m_hold = 0;
                end
            end
        end else begin
            others = r;
            others[m_owner] = 1'b0;
            if (!r[m_owner]) begin
                m_owner = -1;
`ifdef ARB_TIMEOUT_EN
            end else if (m_hold == HOLD - 1 && others != 0) begin
                m_owner = -1;
            end else if (m_hold < HOLD - 1) begin
                m_hold++;
`endif
            end
        end
        m_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // --- single request ---
        add(1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 0, 0);
        add(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, 0);
        // --- all requesting, each owner releases after 2 grant cycles ---
        add(1, 4'b1111, 4'b1010, 4'b0001, 2'd0, 0, 0);
        add(0, 4'b1111, 4'b1010, 4'b0001, 2'd0, 0, 1);
        add(0, 4'b1110, 4'b1010, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b1111, 4'b1010, 4'b0010, 2'd1, 0, 0);
        add(0, 4'b1111, 4'b1010, 4'b0010, 2'd1, 1, 1);
        add(0, 4'b1101, 4'b1010, 4'b0000, 2'd1, 1, 1);
        add(0, 4'b1111, 4'b1010, 4'b0100, 2'd2, 0, 0);
        add(0, 4'b1111, 4'b1010, 4'b0100, 2'd2, 0, 1);
        add(0, 4'b1011, 4'b1010, 4'b0000, 2'd2, 0, 1);
        add(0, 4'b1111, 4'b1010, 4'b1000, 2'd3, 0, 0);
        add(0, 4'b1111, 4'b1010, 4'b1000, 2'd3, 1, 1);
        add(0, 4'b0111, 4'b1010, 4'b0000, 2'd3, 1, 1);
        add(0, 4'b1111, 4'b1010, 4'b0001, 2'd0, 0, 0);
        add(0, 4'b0000, 4'b1010, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b0000, 4'b1010, 4'b0000, 2'd0, 0, 0);
        // --- same-requester re-grant still gets the dead cycle ---
        add(0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 0, 0);
        add(0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1, 1);
        add(0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 0, 0);
        add(0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1, 1);
        // --- rotation skip: last = 1, req 1001 -> 3 ---
        add(1, 4'b0010, 4'b1000, 4'b0010, 2'd1, 0, 0);
        add(0, 4'b0000, 4'b1000, 4'b0000, 2'd1, 0, 1);
        add(0, 4'b1001, 4'b1000, 4'b1000, 2'd3, 0, 0);
        add(0, 4'b0000, 4'b1000, 4'b0000, 2'd3, 1, 1);
        // --- non-owner toggling leaves owner 2 alone ---
        add(1, 4'b0100, 4'b0100, 4'b0100, 2'd2, 0, 0);
        add(0, 4'b0101, 4'b0100, 4'b0100, 2'd2, 1, 1);
        add(0, 4'b1100, 4'b0100, 4'b0100, 2'd2, 1, 1);
        add(0, 4'b0101, 4'b0100, 4'b0100, 2'd2, 1, 1);
        add(0, 4'b1100, 4'b0100, 4'b0100, 2'd2, 1, 1);
        add(0, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1, 1);
        add(0, 4'b0000, 4'b0100, 4'b0000, 2'd2, 0, 0);

        // Reset state, checked before any edge with reset released.
        #1;
        check_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        foreach (vt[i]) begin
            if (vt[i].rst) do_reset();
            @(negedge clk);
            req  = vt[i].req;
            data = vt[i].data;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vt[i].gnt, vt[i].sel, vt[i].out, vt[i].valid);
        end

        // --- reset asserted mid-grant clears outputs without a clock edge ---
        do_reset();
        @(negedge clk);
        req = 4'b0100; data = 4'b0100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_all("midrst.pre", 4'b0100, 2'd2, 1'b1, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_all("midrst.async", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        req = 4'b1111;
        @(posedge clk); #1;
        check_all("midrst.held", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_all("midrst.first", 4'b0001, 2'd0, 1'b0, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // --- owner 1 preempted after HOLD cycles by pending requester 2 ---
        do_reset();
        @(negedge clk);
        req = 4'b0010;
        @(posedge clk); #1;
        check_all("tmo.g0", 4'b0010, 2'd1, 1'b0, 1'b0);
        @(negedge clk);
        req = 4'b0110;
        for (int c = 1; c < HOLD; c++) begin
            @(posedge clk); #1;
            check_all($sformatf("tmo.g%0d", c), 4'b0010, 2'd1, 1'b0, 1'b1);
        end
        @(posedge clk); #1;
        check_all("tmo.idle", 4'b0000, 2'd1, 1'b0, 1'b1);
        @(posedge clk); #1;
        check_all("tmo.next", 4'b0100, 2'd2, 1'b0, 1'b0);
        // --- without a competitor the grant persists ---
        do_reset();
        @(negedge clk);
        req = 4'b0010;
        for (int c = 0; c < 2 * HOLD; c++) begin
            @(posedge clk); #1;
            check_all($sformatf("tmo.solo%0d", c), 4'b0010, 2'd1, 1'b0, c != 0);
        end
`endif

        // --- randomized run against the model ---
        do_reset();
        model_reset();
        for (int t = 0; t < 400; t++) begin
            logic [3:0] r;
            @(negedge clk);
            r = 4'($urandom_range(0, 15));
            // Keep the owner requesting most of the time so grants get long.
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            req  = r;
            data = 4'($urandom_range(0, 15));
            model_step(req, data);
            @(posedge clk); #1;
            check_all($sformatf("rnd%0d", t), m_gnt, 2'(m_sel), m_out, m_valid);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
